wrr_packet_arbiter: RTL and testbench

- Weighted round-robin packet arbiter. Merges REQ_NUM valid/ready/last packet streams onto one output stream.
- Once a port is granted, the grant is held until its packet's last beat is accepted.
- A port may send up to its configured weight of consecutive packets before the grant rotates.
- Sits in front of a shared packet sink, e.g. an egress FIFO or a serializer.

---
 rtl/wrr_arb_pkg.sv | 25 ++
 rtl/rr_mask_pick.sv | 30 +++
 rtl/wrr_packet_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_wrr_packet_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wrr_arb_pkg.sv
// Shared definitions for the weighted round-robin packet arbiter:
// state encoding, packet-counter width and a one-hot to index helper.
package wrr_arb_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_LOCK = ST_LOCK
    } state_t;

    localparam int PKT_CNT_WD = 16;

    // Index of the set bit of a one-hot vector (up to 32 ports).
    function automatic int onehot_to_idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_mask_pick.sv
// Round-robin pick: lowest set bit of the masked request vector, falling back
// to the lowest set bit of the full vector. Also produces the mask that
// excludes the current owner and every port below it.
module rr_mask_pick #(
    parameter int REQ_NUM = 4
) (
    input  logic [REQ_NUM-1:0] eligible,
    input  logic [REQ_NUM-1:0] mask,
    input  logic [REQ_NUM-1:0] owner_oh,
    output logic [REQ_NUM-1:0] pick_oh,
    output logic               pick_valid,
    output logic [REQ_NUM-1:0] next_mask
);

    localparam logic [REQ_NUM-1:0] ONE = {{(REQ_NUM-1){1'b0}}, 1'b1};

    logic [REQ_NUM-1:0] masked;
    logic [REQ_NUM-1:0] cand;
    logic [REQ_NUM-1:0] rot_mask;

    assign masked     = eligible & mask;
    assign cand       = (masked != '0) ? masked : eligible;
    assign pick_oh    = cand & (~cand + ONE);
    assign pick_valid = |eligible;

    // Wrapping past the top port re-opens the whole mask.
    assign rot_mask  = ~(owner_oh | (owner_oh - ONE));
    assign next_mask = (rot_mask == '0) ? '1 : rot_mask;

endmodule

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin packet arbiter: merges REQ_NUM valid/ready/last
// streams, holding the grant for a whole packet and letting each port send
// up to its weight of packets per turn. Optional per-port completed-packet
// counters are enabled with the macro WRR_PKT_STATS_EN.
module wrr_packet_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int REQ_NUM   = 4,
    parameter int DATA_WD   = 8,
    parameter int WEIGHT_WD = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [REQ_NUM-1:0]           valid_in,
    input  logic [REQ_NUM*DATA_WD-1:0]   data_in,
    input  logic [REQ_NUM-1:0]           last_in,
    output logic [REQ_NUM-1:0]           ready_in,
    output logic                         valid_out,
    output logic [DATA_WD-1:0]           data_out,
    output logic                         last_out,
    input  logic                         ready_out,
    input  logic [REQ_NUM*WEIGHT_WD-1:0] weight_cfg,
    input  logic                         cfg_update,
    output logic [$clog2(REQ_NUM)-1:0]   owner_idx
`ifdef WRR_PKT_STATS_EN
    ,
    output logic [REQ_NUM*PKT_CNT_WD-1:0] pkt_cnt,
    input  logic                          stats_clr
`endif
);

    localparam int IDX_W = $clog2(REQ_NUM);
    localparam logic [REQ_NUM-1:0] ONE = {{(REQ_NUM-1){1'b0}}, 1'b1};

    // Credit decrement that floors at zero.
    function automatic logic [WEIGHT_WD-1:0] sat_dec(input logic [WEIGHT_WD-1:0] v);
        return (v != '0) ? v - WEIGHT_WD'(1) : '0;
    endfunction

    function automatic logic [WEIGHT_WD-1:0] clamp_min(input logic [WEIGHT_WD-1:0] a,
                                                       input logic [WEIGHT_WD-1:0] b);
        return (b < a) ? b : a;
    endfunction

    function automatic logic [WEIGHT_WD-1:0] weight_of(input logic [REQ_NUM*WEIGHT_WD-1:0] w,
                                                       input logic [IDX_W-1:0] idx);
        return w[idx*WEIGHT_WD +: WEIGHT_WD];
    endfunction

    state_t                       state;
    logic [IDX_W-1:0]             owner;
    logic [REQ_NUM-1:0]           mask;
    logic [WEIGHT_WD-1:0]         credit;
    logic [REQ_NUM*WEIGHT_WD-1:0] weight_r;
    logic [REQ_NUM*WEIGHT_WD-1:0] weight_shadow;
    logic                         cfg_pending;

    logic                         in_lock;
    logic [REQ_NUM-1:0]           weight_nz;
    logic [REQ_NUM-1:0]           eligible;
    logic [REQ_NUM-1:0]           owner_oh;
    logic [REQ_NUM-1:0]           pick_oh;
    logic [REQ_NUM-1:0]           next_mask;
    logic                         pick_valid;
    logic [IDX_W-1:0]             pick_idx;
    logic                         pkt_end;
    logic                         apply_cfg;
    logic [REQ_NUM*WEIGHT_WD-1:0] weight_apply;
    logic [WEIGHT_WD-1:0]         credit_end;

    assign in_lock   = (state == S_LOCK);
    assign owner_oh  = ONE << owner;
    assign owner_idx = owner;

    // A port with weight zero never competes for the grant.
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            weight_nz[i] = (weight_r[i*WEIGHT_WD +: WEIGHT_WD] != '0);
        end
    end

    assign eligible = valid_in & weight_nz;

    rr_mask_pick #(.REQ_NUM(REQ_NUM)) u_pick (
        .eligible   (eligible),
        .mask       (mask),
        .owner_oh   (owner_oh),
        .pick_oh    (pick_oh),
        .pick_valid (pick_valid),
        .next_mask  (next_mask)
    );

    assign pick_idx = IDX_W'(onehot_to_idx(32'(pick_oh)));

    // Owner's stream is passed straight through while locked; all quiet in IDLE.
    always_comb begin
        valid_out = 1'b0;
        data_out  = '0;
        last_out  = 1'b0;
        ready_in  = '0;
        if (in_lock) begin
            valid_out = valid_in[owner];
            data_out  = data_in[owner*DATA_WD +: DATA_WD];
            last_out  = last_in[owner] & valid_in[owner];
            ready_in  = owner_oh & {REQ_NUM{ready_out}};
        end
    end

    assign pkt_end = in_lock & valid_out & ready_out & last_out;

    // A weight update arriving on the packet-end cycle is the newest one and wins.
    assign apply_cfg    = pkt_end & (cfg_pending | cfg_update);
    assign weight_apply = cfg_update ? weight_cfg : weight_shadow;
    assign credit_end   = apply_cfg ? clamp_min(sat_dec(credit), weight_of(weight_apply, owner))
                                    : sat_dec(credit);

    // Grant FSM: pick in IDLE, hold in LOCK until the last beat, then rotate if credit is spent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            owner         <= '0;
            mask          <= '1;
            credit        <= '0;
            weight_r      <= {REQ_NUM{WEIGHT_WD'(1)}};
            weight_shadow <= '0;
            cfg_pending   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        state <= S_LOCK;
                        owner <= pick_idx;
                        // Same owner keeps its remaining credit; a new turn reloads it.
                        if (pick_idx != owner || credit == '0) begin
                            credit <= weight_of(weight_r, pick_idx);
                        end
                        if (cfg_update) begin
                            weight_shadow <= weight_cfg;
                            cfg_pending   <= 1'b1;
                        end
                    end else if (cfg_update) begin
                        weight_r <= weight_cfg;
                    end
                end
                S_LOCK: begin
                    if (pkt_end) begin
                        state  <= S_IDLE;
                        credit <= credit_end;
                        if (credit_end == '0) begin
                            mask <= next_mask;
                        end
                        if (apply_cfg) begin
                            weight_r    <= weight_apply;
                            cfg_pending <= 1'b0;
                        end
                    end else if (cfg_update) begin
                        weight_shadow <= weight_cfg;
                        cfg_pending   <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WRR_PKT_STATS_EN
    function automatic logic [PKT_CNT_WD-1:0] sat_inc(input logic [PKT_CNT_WD-1:0] v);
        return (v != '1) ? v + PKT_CNT_WD'(1) : v;
    endfunction

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_cnt
        logic [PKT_CNT_WD-1:0] cnt;

        // Completed-packet counter; a clear beats a same-cycle increment.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (stats_clr) begin
                cnt <= '0;
            end else if (pkt_end && owner_oh[g]) begin
                cnt <= sat_inc(cnt);
            end
        end

        assign pkt_cnt[g*PKT_CNT_WD +: PKT_CNT_WD] = cnt;
    end
`endif

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Directed testbench for wrr_packet_arbiter (4 ports, 8-bit data, 4-bit weights).
module tb_wrr_packet_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid_in;
    logic [31:0] data_in;
    logic [3:0]  last_in;
    logic [3:0]  ready_in;
    logic        valid_out;
    logic [7:0]  data_out;
    logic        last_out;
    logic        ready_out;
    logic [15:0] weight_cfg;
    logic        cfg_update;
    logic [1:0]  owner_idx;
`ifdef WRR_PKT_STATS_EN
    logic [63:0] pkt_cnt;
    logic        stats_clr;
`endif

    int checks = 0;
    int errors = 0;
    int exp_seq[16];

    always #5 clk = ~clk;

    wrr_packet_arbiter #(.REQ_NUM(4), .DATA_WD(8), .WEIGHT_WD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .last_in    (last_in),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .last_out   (last_out),
        .ready_out  (ready_out),
        .weight_cfg (weight_cfg),
        .cfg_update (cfg_update),
        .owner_idx  (owner_idx)
`ifdef WRR_PKT_STATS_EN
        ,
        .pkt_cnt    (pkt_cnt),
        .stats_clr  (stats_clr)
`endif
    );

    task automatic do_reset();
        rst_n      = 1'b0;
        valid_in   = '0;
        data_in    = '0;
        last_in    = '0;
        ready_out  = 1'b0;
        weight_cfg = '0;
        cfg_update = 1'b0;
`ifdef WRR_PKT_STATS_EN
        stats_clr  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input logic [15:0] w);
        valid_in   = '0;
        weight_cfg = w;
        cfg_update = 1'b1;
        @(posedge clk);
        #1;
        cfg_update = 1'b0;
    endtask

    // Every active port always offers a packet of 'beats' beats; data = {port, beat}.
    task automatic run_traffic(input string name, input logic [3:0] act, input int beats,
                               input int npkts, input int cfg_at, input logic [15:0] cfg_val);
        int bc[4];
        int done, cyc, p, b;
        bit prev_last, cfg_now, cfg_done;
        for (int i = 0; i < 4; i++) bc[i] = 0;
        done = 0; cyc = 0; prev_last = 0; cfg_now = 0; cfg_done = 0;
        while (done < npkts && cyc < 400) begin
            for (int i = 0; i < 4; i++) begin
                valid_in[i]       = act[i];
                data_in[i*8 +: 8] = {4'(i), 4'(bc[i])};
                last_in[i]        = (bc[i] == beats - 1);
            end
            ready_out  = !cfg_now;
            cfg_update = cfg_now;
            if (cfg_now) weight_cfg = cfg_val;
            @(negedge clk);
            cfg_now = 0;
            if (prev_last) begin
                checks++;
                if (valid_out !== 1'b0)
                    $display("FAIL %s bubble: valid_out=%0b required 0", name, valid_out);
                if (valid_out !== 1'b0) errors++;
            end
            prev_last = 0;
            if (valid_out === 1'b1 && ready_out === 1'b1) begin
                p = int'(data_out[7:4]);
                b = int'(data_out[3:0]);
                checks++;
                if (ready_in !== 4'(1 << p) || owner_idx !== 2'(p)) begin
                    errors++;
                    $display("FAIL %s grant: ready_in=%b owner_idx=%0d required port %0d", name, ready_in, owner_idx, p);
                end
                checks++;
                if (last_out !== (b == beats - 1)) begin
                    errors++;
                    $display("FAIL %s last: last_out=%0b at beat %0d", name, last_out, b);
                end
                if (last_out === 1'b1) begin
                    checks++;
                    if (p !== exp_seq[done]) begin
                        errors++;
                        $display("FAIL %s order pkt %0d: port=%0d required %0d", name, done, p, exp_seq[done]);
                    end
                    done++;
                    prev_last = 1;
                    bc[p] = 0;
                end else begin
                    bc[p]++;
                end
                if (cfg_at == done && last_out !== 1'b1 && !cfg_done) begin
                    cfg_now  = 1;
                    cfg_done = 1;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        cfg_update = 1'b0;
        checks++;
        if (done != npkts) begin
            errors++;
            $display("FAIL %s timeout: packets=%0d required %0d", name, done, npkts);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        valid_in = 4'b1111;
        last_in  = 4'b1111;
        data_in  = 32'hA5A5A5A5;
        ready_out = 1'b1;
        weight_cfg = '0;
        cfg_update = 1'b0;
`ifdef WRR_PKT_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset valid_out: got %0b required 0", valid_out); end
        checks++; if (last_out !== 1'b0) begin errors++; $display("FAIL reset last_out: got %0b required 0", last_out); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset data_out: got %0h required 0", data_out); end
        checks++; if (ready_in !== 4'b0000) begin errors++; $display("FAIL reset ready_in: got %b required 0000", ready_in); end
        checks++; if (owner_idx !== 2'd0) begin errors++; $display("FAIL reset owner_idx: got %0d required 0", owner_idx); end
        do_reset();
    endtask

    task automatic test_round_robin();
        do_reset();
        exp_seq = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_traffic("rr", 4'b1111, 1, 5, -1, 16'h0);
    endtask

    task automatic test_weighted();
        do_reset();
        load_weights(16'h1113);
        exp_seq = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_traffic("wrr", 4'b1111, 2, 7, -1, 16'h0);
    endtask

    task automatic test_weight_zero();
        do_reset();
        load_weights(16'h1011);
        valid_in  = 4'b0100;
        last_in   = 4'b0101;
        data_in   = 32'h002A0001;
        ready_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b0 || ready_in !== 4'b0000) begin
                errors++;
                $display("FAIL wzero idle: valid_out=%0b ready_in=%b required 0/0000", valid_out, ready_in);
            end
            @(posedge clk); #1;
        end
        valid_in = 4'b0101;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b1 || owner_idx !== 2'd0 || ready_in !== 4'b0001) begin
            errors++;
            $display("FAIL wzero grant: valid_out=%0b owner=%0d ready_in=%b required 1/0/0001", valid_out, owner_idx, ready_in);
        end
        @(posedge clk); #1;
        load_weights(16'h0000);
        valid_in = 4'b1111;
        last_in  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b0 || ready_in !== 4'b0000) begin
                errors++;
                $display("FAIL allzero idle: valid_out=%0b ready_in=%b required 0/0000", valid_out, ready_in);
            end
            @(posedge clk); #1;
        end
        valid_in = '0;
    endtask

    task automatic test_stall();
        int v1[9] = '{1, 1, 1, 0, 0, 1, 1, 0, 0};
        int bt[9] = '{0, 0, 1, 1, 1, 1, 2, 2, 2};
        int lt[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        int rd[9] = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
        int ev[9] = '{0, 1, 1, 0, 0, 1, 1, 0, 1};
        int er[9] = '{0, 2, 0, 2, 2, 2, 2, 0, 8};
        int ed[9] = '{0, 'h10, 'h11, 'h11, 'h11, 'h11, 'h12, 0, 'h30};
        int el[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
        int eo[9] = '{-1, 1, 1, 1, 1, 1, 1, -1, 3};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            valid_in   = {1'b1, 1'b0, 1'(v1[c]), 1'b0};
            last_in    = {1'b1, 1'b0, 1'(lt[c]), 1'b0};
            data_in    = {8'h30, 8'h00, 8'h10 + 8'(bt[c]), 8'h00};
            ready_out  = 1'(rd[c]);
            @(negedge clk);
            checks++;
            if (valid_out !== 1'(ev[c]) || ready_in !== 4'(er[c]) || data_out !== 8'(ed[c]) || last_out !== 1'(el[c])) begin
                errors++;
                $display("FAIL stall cyc %0d: v=%0b rdy=%b d=%0h l=%0b required v=%0d rdy=%0h d=%0h l=%0d",
                         c, valid_out, ready_in, data_out, last_out, ev[c], er[c], ed[c], el[c]);
            end
            if (eo[c] >= 0) begin
                checks++;
                if (owner_idx !== 2'(eo[c])) begin
                    errors++;
                    $display("FAIL stall owner cyc %0d: got %0d required %0d", c, owner_idx, eo[c]);
                end
            end
            @(posedge clk); #1;
        end
        valid_in = '0;
    endtask

    task automatic test_cfg_in_lock();
        // Update arrives during port 0's second packet (credit 2): clamp to 1, one more packet.
        do_reset();
        load_weights(16'h1113);
        exp_seq = '{0, 0, 0, 1, 2, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        run_traffic("cfg_lock_a", 4'b1111, 2, 8, 1, 16'h1111);
        // Update arrives during port 0's first packet (credit 3): clamp cuts its turn short.
        do_reset();
        load_weights(16'h1113);
        exp_seq = '{0, 0, 1, 2, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_traffic("cfg_lock_b", 4'b1111, 2, 7, 0, 16'h1111);
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        valid_in  = 4'b0100;
        last_in   = 4'b0000;
        data_in   = 32'h00210000;
        ready_out = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b1 || ready_in !== 4'b0100) begin
            errors++;
            $display("FAIL rstmid lock: valid_out=%0b ready_in=%b required 1/0100", valid_out, ready_in);
        end
        @(posedge clk); #1;
        data_in = 32'h00220000;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || ready_in !== 4'b0000 || owner_idx !== 2'd0) begin
            errors++;
            $display("FAIL rstmid drop: valid_out=%0b ready_in=%b owner=%0d required 0/0000/0", valid_out, ready_in, owner_idx);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        valid_in = 4'b0101;
        last_in  = 4'b0101;
        data_in  = 32'h00230001;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b1 || owner_idx !== 2'd0 || data_out !== 8'h01) begin
            errors++;
            $display("FAIL rstmid restart: valid_out=%0b owner=%0d data=%0h required 1/0/01", valid_out, owner_idx, data_out);
        end
        @(posedge clk); #1;
        valid_in = '0;
    endtask

`ifdef WRR_PKT_STATS_EN
    task automatic test_stats();
        do_reset();
        exp_seq = '{3, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_traffic("stats", 4'b1000, 1, 5, -1, 16'h0);
        checks++;
        if (pkt_cnt !== 64'h0005_0000_0000_0000) begin
            errors++;
            $display("FAIL stats count: pkt_cnt=%0h required 0005000000000000", pkt_cnt);
        end
        @(negedge clk);
        @(posedge clk); #1;
        stats_clr = 1'b1;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b1 || last_out !== 1'b1) begin
            errors++;
            $display("FAIL stats sixth: valid_out=%0b last_out=%0b required 1/1", valid_out, last_out);
        end
        @(posedge clk); #1;
        stats_clr = 1'b0;
        valid_in  = '0;
        @(negedge clk);
        checks++;
        if (pkt_cnt !== 64'h0) begin
            errors++;
            $display("FAIL stats clear: pkt_cnt=%0h required 0", pkt_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_weighted();
        test_weight_zero();
        test_stall();
        test_cfg_in_lock();
        test_reset_mid_packet();
`ifdef WRR_PKT_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
